// File: rtl/regfile_wr_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : regfile_wr_arbiter_if                                     |
// | Brief    : Two-requester write port bundle and register bank outputs |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface regfile_wr_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              hold;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              last_grant;
    logic [7:0]        wr_count;

    modport master (
        output hold,
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  wr_en, wr_addr, wr_data, last_grant, wr_count
    );

    modport slave (
        input  hold,
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output wr_en, wr_addr, wr_data, last_grant, wr_count
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : regfile_wr_arbiter                                        |
// | Brief    : Round-robin arbiter for two register-bank write sources   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module regfile_wr_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input wire logic            clk,
    input wire logic            rst,
    regfile_wr_arbiter_if.slave bus
);
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_last_grant;
    logic [7:0]        r_wr_count;

    logic              w_req0_ready;
    logic              w_req1_ready;
    logic              w_xfer0;
    logic              w_xfer1;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_wr_fire;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;
        if (!rst && !bus.hold) begin
            w_req0_ready = bus.req0_valid && (!bus.req1_valid || r_last_grant);
            w_req1_ready = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
        end
    end

    assign w_xfer0 = bus.req0_valid && w_req0_ready;
    assign w_xfer1 = bus.req1_valid && w_req1_ready;

    always_comb begin
        w_sel_addr = bus.req0_addr;
        w_sel_data = bus.req0_data;
        if (w_xfer1) begin
            w_sel_addr = bus.req1_addr;
            w_sel_data = bus.req1_data;
        end
    end

    // Register 0 reads as zero, so a write to it is accepted but dropped.
    assign w_wr_fire = (w_xfer0 || w_xfer1) && (w_sel_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_last_grant <= 1'b1;
            r_wr_count   <= 8'd0;
        end else begin
            r_wr_en <= w_wr_fire;
            if (w_wr_fire) begin
                r_wr_addr  <= w_sel_addr;
                r_wr_data  <= w_sel_data;
                r_wr_count <= r_wr_count + 8'd1;
            end
            if (w_xfer0) begin
                r_last_grant <= 1'b0;
            end else if (w_xfer1) begin
                r_last_grant <= 1'b1;
            end
        end
    end

    assign bus.req0_ready = w_req0_ready;
    assign bus.req1_ready = w_req1_ready;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.last_grant = r_last_grant;
    assign bus.wr_count   = r_wr_count;
endmodule
`default_nettype wire

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, width of register data.
REQ-002 Parameter ADDR_W, default 2, width of register index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 hold  input  1  when 1, no new grants are issued.
REQ-006 req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-007 req0_addr  input  ADDR_W  requester 0 destination register.
REQ-008 req0_data  input  DATA_W  requester 0 write data.
REQ-009 req0_ready  output  1  requester 0 write accepted this cycle.
REQ-010 req1_valid, req1_addr, req1_data, req1_ready: same as REQ-006..009 for requester 1 (memory load).
REQ-011 wr_en  output  1  register bank write strobe, registered.
REQ-012 wr_addr  output  ADDR_W  register bank write index, registered.
REQ-013 wr_data  output  DATA_W  register bank write data, registered.
REQ-014 last_grant  output  1  index of most recently granted requester.
REQ-015 wr_count  output  8  count of completed bank writes.

Function
REQ-016 Transfer on requester n occurs in a cycle where reqn_valid=1 and reqn_ready=1.
REQ-017 reqn_ready is combinational from valid, hold, rst and priority state; requesters hold valid/addr/data stable until the transfer.
REQ-018 At most one of req0_ready, req1_ready is 1 in any cycle.
REQ-019 hold=1 or rst=1 forces both readys to 0.
REQ-020 Only one valid: that requester gets ready=1 (hold=0).
REQ-021 Both valid: requester != last_grant gets ready=1 (round-robin); loser keeps valid and is granted the next cycle unless hold.
REQ-022 last_grant updates to the granted index on the edge following each transfer; unchanged with no transfer.
REQ-023 Transfer with addr != 0: next cycle wr_en=1, wr_addr/wr_data = transferred values; latency exactly 1 cycle.
REQ-024 Transfer with addr == 0: handshake completes, last_grant updates, but wr_en stays 0 next cycle (register 0 is hard-wired zero); wr_count does not increment.
REQ-025 wr_en is 1 for exactly one cycle per non-zero-address transfer; back-to-back transfers give wr_en=1 on consecutive cycles (throughput 1 write/cycle).
REQ-026 No transfer in a cycle: next cycle wr_en=0; wr_addr/wr_data hold previous values.
REQ-027 wr_count increments by 1 on each cycle with wr_en=1, wraps 255 -> 0.
REQ-028 hold asserted the cycle after a transfer does not suppress the pending wr_en for that transfer.
REQ-029 Internal state is exactly: wr_en/wr_addr/wr_data register, last_grant, wr_count; no buffering beyond one write.

Reset
REQ-030 rst=1 at an edge sets wr_en=0, wr_addr=0, wr_data=0, last_grant=1 (so req0 wins the first tie), wr_count=0.
REQ-031 rst asserted the cycle after a transfer cancels its write: wr_en=0 after that edge, wr_count not incremented.
REQ-032 rst has priority over every other input; no transfer occurs in any cycle with rst=1.

Verification
REQ-033 After reset, both valid, addrs 1/2, data 0x11/0x22 -> cycle0 req0_ready=1, cycle1 wr_en=1 addr1 data 0x11 and req1_ready=1, cycle2 wr_en=1 addr2 data 0x22, wr_count=2.
REQ-034 Both valid continuously for 6 cycles, non-zero addrs -> grants alternate 0,1,0,1,0,1; wr_en=1 for 6 consecutive cycles.
REQ-035 req0_valid with addr 0, data 0xFF -> req0_ready=1, next cycle wr_en=0, wr_count unchanged, last_grant=0.
REQ-036 hold=1 with both valid for 3 cycles -> readys 0, wr_en 0; transfer issued cycle before hold still writes; hold released -> grant resumes round-robin.
REQ-037 Transfer then rst=1 next cycle -> wr_en=0, wr_count=0, last_grant=1.
REQ-038 256 single-requester writes to addr 3 -> wr_count wraps to 0, wr_en never high two cycles after valid drops.
